// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_if
//  Description : Byte-stream load handshake between a program source and the
//                imem_loader instruction store.
//                  load_start  - one-cycle request to begin a frame
//                  byte_in     - load data byte
//                  byte_valid  - byte_in carries a byte this cycle
//                  byte_ready  - loader accepts a byte this cycle
//                A byte transfers on a rising edge with byte_valid & byte_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
    parameter int DATA_W = 8
);
    logic              load_start;
    logic [DATA_W-1:0] byte_in;
    logic              byte_valid;
    logic              byte_ready;

    // Program source side.
    modport master (
        output load_start,
        output byte_in,
        output byte_valid,
        input  byte_ready
    );

    // Loader side.
    modport slave (
        input  load_start,
        input  byte_in,
        input  byte_valid,
        output byte_ready
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : 2^ADDR_W x DATA_W instruction store with a framed byte-stream
//                loader. The read side (Read_Address -> Instruction) replaces
//                a read-only instruction memory. A frame is
//                  length (0 = 2^DATA_W), data bytes, checksum
//                where length + data + checksum must sum to 0 mod 2^DATA_W.
//                The CPU is held off from frame start until a frame ends with
//                a good checksum.
//  Ports       : clk          - system clock, rising edge
//                Reset        - asynchronous active-low reset
//                Read_Address - CPU fetch address
//                Instruction  - mem[Read_Address], FILL while cpu_hold=1
//                ld           - load handshake (slave side)
//                busy         - frame in progress
//                done         - one-cycle pulse, frame checksum good
//                error        - sticky, last frame checksum bad
//                cpu_hold     - CPU must stay in reset / not fetch
//                words_loaded - data bytes written in current/last frame
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int                ADDR_W = 8,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] FILL   = 8'h00
) (
    input  wire logic              clk,
    input  wire logic              Reset,
    input  wire logic [ADDR_W-1:0] Read_Address,
    output logic      [DATA_W-1:0] Instruction,
    imem_loader_if.slave           ld,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic                   cpu_hold,
    output logic      [ADDR_W-1:0] words_loaded
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LEN  = 3'd1;
    localparam logic [2:0] c_DATA = 3'd2;
    localparam logic [2:0] c_CSUM = 3'd3;
    localparam logic [2:0] c_FIN  = 3'd4;

    localparam logic [ADDR_W-1:0] c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W:0]   c_REM_ONE  = {{DATA_W{1'b0}}, 1'b1};
    // A length byte of zero stands for a full 2^DATA_W byte payload.
    localparam logic [DATA_W:0]   c_REM_FULL = {1'b1, {DATA_W{1'b0}}};

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] words_q;
    logic [DATA_W-1:0] sum_q;
    logic [DATA_W:0]   rem_q;
    logic              error_q;
    logic              hold_q;

    logic [DATA_W-1:0] mem_q [0:(2**ADDR_W)-1];

    logic              w_accept;
    logic              w_last_data;
    logic [DATA_W-1:0] w_sum_next;

    assign w_accept    = ld.byte_valid & ld.byte_ready;
    assign w_last_data = (rem_q == c_REM_ONE);
    assign w_sum_next  = sum_q + ld.byte_in;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: if (ld.load_start)              state_d = c_LEN;
            c_LEN:  if (w_accept)                   state_d = c_DATA;
            c_DATA: if (w_accept && w_last_data)    state_d = c_CSUM;
            c_CSUM: if (w_accept)                   state_d = c_FIN;
            c_FIN:                                  state_d = c_IDLE;
            default:                                state_d = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (pure decodes of the registered state)
    // ------------------------------------------------------------------
    always_comb begin
        ld.byte_ready = (state_q == c_LEN) || (state_q == c_DATA) ||
                        (state_q == c_CSUM);
        busy          = (state_q != c_IDLE);
        // error_q was resolved on the checksum edge, so in FIN it tells
        // whether this frame was good.
        done          = (state_q == c_FIN) && !error_q;
    end

    // ------------------------------------------------------------------
    // Frame datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            addr_q  <= '0;
            words_q <= '0;
            sum_q   <= '0;
            rem_q   <= '0;
            error_q <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            case (state_q)
                c_IDLE: begin
                    if (ld.load_start) begin
                        addr_q  <= '0;
                        words_q <= '0;
                        sum_q   <= '0;
                        error_q <= 1'b0;
                        hold_q  <= 1'b1;
                    end
                end
                c_LEN: begin
                    if (w_accept) begin
                        sum_q <= w_sum_next;
                        rem_q <= (ld.byte_in == '0) ? c_REM_FULL
                                                    : {1'b0, ld.byte_in};
                    end
                end
                c_DATA: begin
                    if (w_accept) begin
                        addr_q  <= addr_q + c_ADDR_ONE;
                        words_q <= words_q + c_ADDR_ONE;
                        sum_q   <= w_sum_next;
                        rem_q   <= rem_q - c_REM_ONE;
                    end
                end
                c_CSUM: begin
                    // Good frame: everything including the checksum sums to 0.
                    if (w_accept) begin
                        error_q <= (w_sum_next != '0);
                    end
                end
                c_FIN: begin
                    // A bad frame keeps the CPU held until a good frame lands.
                    if (!error_q) begin
                        hold_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage is never reset; a write only happens while a frame is in DATA,
    // which an asserted Reset rules out.
    always_ff @(posedge clk) begin
        if ((state_q == c_DATA) && w_accept) begin
            mem_q[addr_q] <= ld.byte_in;
        end
    end

    assign Instruction  = hold_q ? FILL : mem_q[Read_Address];
    assign error        = error_q;
    assign cpu_hold     = hold_q;
    assign words_loaded = words_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Directed self-checking bench for imem_loader. Inputs are
//                driven and outputs sampled on the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       Reset;
    logic [7:0] Read_Address;
    logic [7:0] Instruction;
    logic       busy;
    logic       done;
    logic       error;
    logic       cpu_hold;
    logic [7:0] words_loaded;

    int vec_cnt = 0;
    int err_cnt = 0;

    imem_loader_if #(.DATA_W(8)) lif ();

    imem_loader #(
        .ADDR_W (8),
        .DATA_W (8),
        .FILL   (8'h00)
    ) dut (
        .clk          (clk),
        .Reset        (Reset),
        .Read_Address (Read_Address),
        .Instruction  (Instruction),
        .ld           (lif),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .cpu_hold     (cpu_hold),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp,
                      input string tag);
        Read_Address = a;
        #1;
        check_val(tag, {24'd0, Instruction}, {24'd0, exp});
    endtask

    task automatic pulse_start();
        lif.load_start = 1'b1;
        @(negedge clk);
        lif.load_start = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        lif.byte_in    = b;
        lif.byte_valid = 1'b1;
        while (!lif.byte_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check_val("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        lif.byte_valid = 1'b0;
    endtask

    // Checks the FIN cycle of a good frame and the idle cycle after it.
    task automatic check_good_end(input logic [7:0] exp_words, input string tag);
        check_val({tag, "_done"},  {31'd0, done},  32'd1);
        check_val({tag, "_err"},   {31'd0, error}, 32'd0);
        @(negedge clk);
        check_val({tag, "_done_low"}, {31'd0, done},     32'd0);
        check_val({tag, "_busy"},     {31'd0, busy},     32'd0);
        check_val({tag, "_hold"},     {31'd0, cpu_hold}, 32'd0);
        check_val({tag, "_words"},    {24'd0, words_loaded}, {24'd0, exp_words});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        Reset          = 1'b0;
        Read_Address   = 8'h00;
        lif.load_start = 1'b0;
        lif.byte_in    = 8'h00;
        lif.byte_valid = 1'b0;

        // ---------------- Reset state ----------------
        repeat (2) @(negedge clk);
        check_val("rst_ready", {31'd0, lif.byte_ready}, 32'd0);
        check_val("rst_busy",  {31'd0, busy},     32'd0);
        check_val("rst_hold",  {31'd0, cpu_hold}, 32'd0);
        check_val("rst_err",   {31'd0, error},    32'd0);
        check_val("rst_done",  {31'd0, done},     32'd0);
        check_val("rst_words", {24'd0, words_loaded}, 32'd0);
        Reset = 1'b1;
        @(negedge clk);

        // ---------------- Good 3-byte frame ----------------
        // 03+11+22+33 = 0x69, so the checksum is 0x100-0x69 = 0x97.
        pulse_start();
        check_val("f1_busy",  {31'd0, busy},     32'd1);
        check_val("f1_hold",  {31'd0, cpu_hold}, 32'd1);
        check_val("f1_ready", {31'd0, lif.byte_ready}, 32'd1);
        rd(8'h01, 8'h00, "f1_fill");
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h97);
        check_good_end(8'd3, "f1");
        rd(8'h00, 8'h11, "f1_m0");
        rd(8'h01, 8'h22, "f1_m1");
        rd(8'h02, 8'h33, "f1_m2");

        // ---------------- Same frame, bad checksum ----------------
        pulse_start();
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'hA6);
        check_val("f2_done", {31'd0, done},  32'd0);
        check_val("f2_err",  {31'd0, error}, 32'd1);
        @(negedge clk);
        check_val("f2_busy", {31'd0, busy},     32'd0);
        check_val("f2_hold", {31'd0, cpu_hold}, 32'd1);
        check_val("f2_err_sticky", {31'd0, error}, 32'd1);
        rd(8'h01, 8'h00, "f2_fill1");
        rd(8'h02, 8'h00, "f2_fill2");

        // ---------------- Recovery frame ----------------
        // 02+44+55 = 0x9B -> checksum 0x65.
        pulse_start();
        check_val("f3_err_clr", {31'd0, error}, 32'd0);
        send_byte(8'h02);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h65);
        check_good_end(8'd2, "f3");
        rd(8'h00, 8'h44, "f3_m0");
        rd(8'h01, 8'h55, "f3_m1");
        rd(8'h02, 8'h33, "f3_m2_kept");

        // ---------------- Full 256-byte frame ----------------
        // Sum of 0..255 = 0x7F80, low byte 0x80 -> checksum 0x80.
        pulse_start();
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) send_byte(8'(i));
        check_val("f4_words_wrap", {24'd0, words_loaded}, 32'd0);
        send_byte(8'h80);
        check_good_end(8'd0, "f4");
        rd(8'h00, 8'h00, "f4_m0");
        rd(8'h80, 8'h80, "f4_m128");
        rd(8'hFF, 8'hFF, "f4_m255");

        // ---------------- Stalls and a stray load_start ----------------
        // 03+AA+BB+CC = 0x234 -> checksum 0xCC.
        pulse_start();
        send_byte(8'h03);
        send_byte(8'hAA);
        @(negedge clk);
        check_val("f5_stall_words", {24'd0, words_loaded}, 32'd1);
        lif.load_start = 1'b1;
        @(negedge clk);
        lif.load_start = 1'b0;
        check_val("f5_no_restart_ready", {31'd0, lif.byte_ready}, 32'd1);
        check_val("f5_no_restart_words", {24'd0, words_loaded}, 32'd1);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hCC);
        check_good_end(8'd3, "f5");
        rd(8'h00, 8'hAA, "f5_m0");
        rd(8'h01, 8'hBB, "f5_m1");
        rd(8'h02, 8'hCC, "f5_m2");
        rd(8'h03, 8'h03, "f5_m3_kept");

        // ---------------- Reset mid-frame ----------------
        pulse_start();
        send_byte(8'h03);
        send_byte(8'h01);
        send_byte(8'h02);
        Reset = 1'b0;
        #1;
        check_val("f6_busy",  {31'd0, busy},     32'd0);
        check_val("f6_hold",  {31'd0, cpu_hold}, 32'd0);
        check_val("f6_ready", {31'd0, lif.byte_ready}, 32'd0);
        check_val("f6_words", {24'd0, words_loaded}, 32'd0);
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        rd(8'h00, 8'h01, "f6_m0");
        rd(8'h01, 8'h02, "f6_m1");
        rd(8'h02, 8'hCC, "f6_m2_kept");

        // ---------------- Bytes offered while idle are ignored ----------------
        lif.byte_in    = 8'h5A;
        lif.byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        lif.byte_valid = 1'b0;
        check_val("idle_busy",  {31'd0, busy}, 32'd0);
        check_val("idle_words", {24'd0, words_loaded}, 32'd0);
        rd(8'h00, 8'h01, "idle_m0");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
